// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
// Shared definitions for the bit serializer block.
//   state_t       : FSM state encoding (IDLE, SHIFT, PARITY)
//   DEFAULT_WIDTH : default number of data bits per word
// PARITY is only ever entered when BIT_SERIALIZER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Load handshake plus serial output bundle for bit_serializer.
//   load_data  : parallel word offered by the producer
//   load_valid : load_data is valid this cycle
//   load_ready : serializer accepts a word this cycle
//   new_D      : serial data bit, meaningful only while en=1
//   en         : bit-valid strobe for the downstream register
//   busy       : a word is being shifted out
//   done       : one-cycle pulse marking completion of a word
// Modports: master = producer/consumer side, slave = serializer side.
// -----------------------------------------------------------------------------
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             new_D;
    logic             en;
    logic             busy;
    logic             done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  new_D,
        input  en,
        input  busy,
        input  done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output new_D,
        output en,
        output busy,
        output done
    );

endinterface : bit_serializer_if

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// clock on new_D, qualified by en. The first bit appears the cycle after the
// word is accepted; done pulses in the first IDLE cycle after the last bit.
//
// Parameters:
//   WIDTH     : data bits per word (2..32)
//   MSB_FIRST : 1 = bit WIDTH-1 first, 0 = bit 0 first
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any word in flight
//   bus     : bit_serializer_if.slave (load_data/valid/ready, new_D, en,
//             busy, done)
// Optional feature:
//   BIT_SERIALIZER_PARITY_EN : when defined, one extra en cycle carrying the
//   even-parity bit (XOR of all data bits) follows the data bits.
// -----------------------------------------------------------------------------
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    bit_serializer_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] count;
    logic             load_ready_q;
    logic             new_d_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_bit;
`endif

    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shreg_rest;

    assign accept = bus.load_valid && load_ready_q;

    // The first bit goes straight to the output flop at acceptance, so the
    // shift register only ever holds the bits that are still to come.
    always_comb begin
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        load_rest  = '0;
        shreg_rest = '0;
        if (MSB_FIRST) begin
            first_bit  = bus.load_data[WIDTH-1];
            load_rest  = bus.load_data << 1;
            next_bit   = shreg[WIDTH-1];
            shreg_rest = shreg << 1;
        end else begin
            first_bit  = bus.load_data[0];
            load_rest  = bus.load_data >> 1;
            next_bit   = shreg[0];
            shreg_rest = shreg >> 1;
        end
    end

    // Single FSM with all outputs registered. count holds the bits remaining
    // including the one currently on new_D, so count==1 marks the last bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            count        <= '0;
            load_ready_q <= 1'b1;
            new_d_q      <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        shreg        <= load_rest;
                        count        <= CNT_LOAD;
                        new_d_q      <= first_bit;
                        en_q         <= 1'b1;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
                        parity_bit   <= ^bus.load_data;
`endif
                    end
                end

                SHIFT: begin
                    if (count == CNT_ONE) begin
                        count <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
                        state        <= PARITY;
                        new_d_q      <= parity_bit;
`else
                        state        <= IDLE;
                        new_d_q      <= 1'b0;
                        en_q         <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        load_ready_q <= 1'b1;
`endif
                    end else begin
                        shreg   <= shreg_rest;
                        new_d_q <= next_bit;
                        count   <= count - CNT_ONE;
                    end
                end

                default: begin
                    // PARITY (or an illegal encoding) always returns to IDLE.
                    state        <= IDLE;
                    new_d_q      <= 1'b0;
                    en_q         <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                    done_q       <= (state == PARITY);
`endif
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.new_D      = new_d_q;
    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance
// (WIDTH=8) sharing clock and reset. Expected streams are hand-computed
// constants; the parity variants apply when BIT_SERIALIZER_PARITY_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int NEN = W + 1;
`else
    localparam int NEN = W;
`endif

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    bit_serializer_if #(.WIDTH(W)) ifm ();
    bit_serializer_if #(.WIDTH(W)) ifl ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifm.slave)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifl.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            ifl.load_valid = v;
            ifl.load_data  = d;
        end else begin
            ifm.load_valid = v;
            ifm.load_data  = d;
        end
    endtask

    task automatic snap(input bit sel, output logic r, output logic e, output logic nd,
                        output logic b, output logic dn);
        r  = sel ? ifl.load_ready : ifm.load_ready;
        e  = sel ? ifl.en         : ifm.en;
        nd = sel ? ifl.new_D      : ifm.new_D;
        b  = sel ? ifl.busy       : ifm.busy;
        dn = sel ? ifl.done       : ifm.done;
    endtask

    // Sends one word and collects the en-qualified stream until done. When
    // inject_at >= 0, a one-cycle load_valid pulse with 8'h3C is driven after
    // that many bits have been seen; it must be ignored.
    task automatic applyStimulus(input string tag, input bit sel, input logic [7:0] data,
                                 input int inject_at, input logic [31:0] exp_bits,
                                 input int exp_busy);
        logic        r, e, nd, b, dn;
        logic [31:0] bits = '0;
        int          n_en = 0;
        int          n_busy = 0;
        bit          got_done = 1'b0;
        logic        rdy_done = 1'b0;
        bit          pending_clear = 1'b0;
        logic        any_late = 1'b0;

        snap(sel, r, e, nd, b, dn);
        checkOutput({tag, " ready_before"}, r, 1'b1);
        drive(sel, 1'b1, data);
        @(negedge clock);
        drive(sel, 1'b0, 8'h00);
        for (int i = 0; i < 40 && !got_done; i++) begin
            snap(sel, r, e, nd, b, dn);
            if (pending_clear) begin
                drive(sel, 1'b0, 8'h5A);
                pending_clear = 1'b0;
            end
            if (e) begin
                bits = {bits[30:0], nd};
                n_en++;
            end
            if (b) n_busy++;
            if (dn) begin
                got_done = 1'b1;
                rdy_done = r;
            end else begin
                if (e && n_en == inject_at) begin
                    drive(sel, 1'b1, 8'h3C);
                    pending_clear = 1'b1;
                end
                @(negedge clock);
            end
        end
        checkOutput({tag, " bits"}, bits, exp_bits);
        checkOutput({tag, " en_count"}, n_en, NEN);
        checkOutput({tag, " busy_count"}, n_busy, exp_busy);
        checkOutput({tag, " done_seen"}, got_done, 1'b1);
        checkOutput({tag, " ready_at_done"}, rdy_done, 1'b1);
        @(negedge clock);
        snap(sel, r, e, nd, b, dn);
        checkOutput({tag, " done_width"}, dn, 1'b0);
        for (int i = 0; i < 3; i++) begin
            snap(sel, r, e, nd, b, dn);
            any_late = any_late | e | b | dn;
            @(negedge clock);
        end
        checkOutput({tag, " quiet_after"}, any_late, 1'b0);
    endtask

    initial begin
        logic        r, e, nd, b, dn;
        logic [31:0] exp_a5, exp_01, exp_07, exp_3c;
        logic [29:0] en_seq, d_seq, exp_en, exp_d;
        logic [31:0] bits;
        int          acc;
        bit          changed, drop;
        logic        watch;

        total = 0;
        bad   = 0;
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_a5 = 32'h14A;   // 1010_0101 then parity 0
        exp_01 = 32'h101;   // 1,0,0,0,0,0,0,0 then parity 1
        exp_07 = 32'h00F;   // 0000_0111 then parity 1
        exp_3c = 32'h078;   // 0011_1100 then parity 0
`else
        exp_a5 = 32'h0A5;
        exp_01 = 32'h080;
        exp_07 = 32'h007;
        exp_3c = 32'h03C;
`endif

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clock);
        snap(1'b0, r, e, nd, b, dn);
        checkOutput("reset msb outputs", {28'd0, e, nd, b, dn}, 32'h0);
        snap(1'b1, r, e, nd, b, dn);
        checkOutput("reset lsb outputs", {28'd0, e, nd, b, dn}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        snap(1'b0, r, e, nd, b, dn);
        checkOutput("ready after reset", r, 1'b1);

        applyStimulus("msb_a5", 1'b0, 8'hA5, -1, exp_a5, NEN);
        applyStimulus("lsb_01", 1'b1, 8'h01, -1, exp_01, NEN);
        applyStimulus("msb_07", 1'b0, 8'h07, -1, exp_07, NEN);
        applyStimulus("busy_ignore", 1'b0, 8'hA5, 2, exp_a5, NEN);

        // Back-to-back: load_valid held through FF then 00; the second word
        // must be taken in the done cycle, leaving exactly one en=0 gap.
        acc     = 0;
        changed = 1'b0;
        drop    = 1'b0;
        en_seq  = '0;
        d_seq   = '0;
        drive(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 30; i++) begin
            if (ifm.load_valid && ifm.load_ready) begin
                acc++;
                if (acc == 2) drop = 1'b1;
            end
            @(negedge clock);
            if (acc == 1 && !changed) begin
                drive(1'b0, 1'b1, 8'h00);
                changed = 1'b1;
            end
            if (drop) begin
                drive(1'b0, 1'b0, 8'h00);
                drop = 1'b0;
            end
            en_seq[i] = ifm.en;
            d_seq[i]  = ifm.new_D;
        end
        for (int i = 0; i < 30; i++) begin
            exp_en[i] = (i < NEN) || (i > NEN && i <= 2 * NEN);
            exp_d[i]  = (i < W);
        end
        checkOutput("b2b accepted", acc, 2);
        checkOutput("b2b en pattern", {2'b00, en_seq}, {2'b00, exp_en});
        checkOutput("b2b data", {2'b00, d_seq & en_seq}, {2'b00, exp_d});

        // Reset after the third bit of A5 aborts the word without done.
        bits = '0;
        drive(1'b0, 1'b1, 8'hA5);
        @(negedge clock);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            snap(1'b0, r, e, nd, b, dn);
            bits = {bits[30:0], nd & e};
            if (i < 2) @(negedge clock);
        end
        checkOutput("abort first bits", bits, 32'h5);
        reset_n = 1'b0;
        #1;
        snap(1'b0, r, e, nd, b, dn);
        checkOutput("abort async", {28'd0, e, nd, b, dn}, 32'h0);
        watch = 1'b0;
        repeat (2) begin
            @(negedge clock);
            watch = watch | ifm.done | ifm.en;
        end
        reset_n = 1'b1;
        #1;
        checkOutput("abort ready", ifm.load_ready, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            watch = watch | ifm.done | ifm.en | ifm.busy;
            if (i < 2) @(negedge clock);
        end
        checkOutput("abort no done", watch, 1'b0);
        applyStimulus("after_abort", 1'b0, 8'h3C, -1, exp_3c, NEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of data bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 load_data  input  WIDTH  SHALL be the parallel word to serialize.
REQ-006 load_valid  input  1  SHALL mean load_data is valid this cycle.
REQ-007 load_ready  output  1  SHALL mean the block accepts a word this cycle.
REQ-008 new_D  output  1  SHALL be the serial data bit, meaningful only while en=1.
REQ-009 en  output  1  SHALL be the bit-valid strobe that gates the downstream register's capture.
REQ-010 busy  output  1  SHALL be high while a word is being shifted out.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking completion of a word.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and PARITY (PARITY reachable only under PARITY_EN).
REQ-013 In IDLE: load_ready=1, en=0, busy=0.
REQ-014 A word SHALL transfer on a rising edge where load_valid=1 and load_ready=1; the word is captured into a shift register and the FSM enters SHIFT.
REQ-015 new_D, en, busy and done SHALL be registered outputs; the first bit SHALL appear in the cycle after acceptance (1-cycle latency).
REQ-016 In SHIFT: en=1, busy=1, load_ready=0; exactly one bit SHALL be emitted per cycle, in the order set by MSB_FIRST, for exactly WIDTH consecutive cycles.
REQ-017 A down-counter of width $clog2(WIDTH+1) SHALL track the bits remaining; leaving SHIFT occurs when the counter reaches 1 at an edge.
REQ-018 After the last data bit the FSM SHALL go to PARITY if PARITY_EN is defined, else to IDLE.
REQ-019 done SHALL pulse high for exactly one cycle, namely the first IDLE cycle after the final emitted bit; load_ready SHALL also be 1 in that cycle.
REQ-020 Back-to-back words SHALL be supported: a word accepted in the done cycle starts emitting on the next cycle, leaving one en=0 gap between words.
REQ-021 load_valid while load_ready=0 SHALL be ignored; load_data changes during SHIFT SHALL NOT affect the word in flight.
REQ-022 en SHALL never be high while in IDLE.

Reset
REQ-023 While reset_n=0, the FSM SHALL be in IDLE, the shift register and counter 0, new_D=0, en=0, busy=0 and done=0; load_ready SHALL read 1 once reset_n is released.
REQ-024 Reset asserted mid-word SHALL abort the word immediately (asynchronously) with no done pulse; no partial bits resume after release.

Configuration
REQ-025 Macro BIT_SERIALIZER_PARITY_EN, when defined, SHALL add the PARITY state: one extra cycle with en=1 and new_D equal to the even-parity bit (XOR of all WIDTH data bits), followed by IDLE.
REQ-026 When BIT_SERIALIZER_PARITY_EN is undefined, each word SHALL occupy exactly WIDTH en cycles and no parity logic shall exist.

Structure
REQ-027 A shared package bit_serializer_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY) and the default WIDTH constant.
REQ-028 The block SHALL be a single module with no sub-modules; the counter and the shift register are inline.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, load 8'hA5 -> new_D=1,0,1,0,0,1,0,1 on 8 consecutive en=1 cycles, then done=1 for one cycle.
REQ-030 MSB_FIRST=0, load 8'h01 -> new_D=1 followed by seven 0s with en=1; busy high for exactly 8 cycles.
REQ-031 PARITY_EN defined: load 8'hA5 -> 9th en cycle new_D=0; load 8'h07 -> 9th en cycle new_D=1.
REQ-032 Hold load_valid=1 with 8'hFF then 8'h00 -> accepted at the done cycle; exactly one en=0 cycle between the two 8-bit bursts.
REQ-033 reset_n low after the 3rd bit of 8'hA5 -> en=0, busy=0, no done pulse; after release, load_ready=1 and a new word serializes correctly.
REQ-034 Pulse load_valid=1 with 8'h3C while busy=1 -> word ignored; output stream is unaffected.
